seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
Parametrised time-multiplexed 7-segment display driver, the successor to the fixed 8-digit scanner. It holds a frame of NUM_DIGITS hex digits with per-digit decimal-point and blank masks, and scans one digit at a time at a prescaled rate. New frames load through a valid/ready handshake and take effect only at a frame boundary, so the display never tears. Adds a PWM brightness control, leading-zero suppression and selectable output polarity. Sits between the application logic and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
CLK_DIV, 100, clk cycles per digit slot (>=2)
SEG_ACT_LOW, 1, 1 = seg and dp pins active-low
DIG_ACT_LOW, 1, 1 = an pins active-low
DUTY_W, $clog2(CLK_DIV+1), width of the duty input (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load_valid  in  1  new frame offered
load_ready  out  1  pending buffer free
load_digits  in  4*NUM_DIGITS  hex codes; digit i = bits [4i+3:4i]; digit 0 is rightmost
load_dp  in  NUM_DIGITS  decimal-point mask (1 = lit)
load_blank  in  NUM_DIGITS  blank mask (1 = digit dark)
lz_en  in  1  leading-zero suppression enable
duty  in  DUTY_W  on-cycles per slot; 0 = dark, >=CLK_DIV = full on
seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
dp  out  1  decimal point, polarity per SEG_ACT_LOW
an  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACT_LOW
frame_done  out  1  1-cycle pulse when the last digit slot ends

Behaviour:
- Reset (clk edge with rst_n=0): prescaler cnt=0, idx=0, active digits=0, active dp=0, active blank=all 1s, pending_full=0. Outputs: all segments, dp and anodes inactive; frame_done=0; load_ready=1 from the first cycle after reset. Reset mid-frame discards both the active and the pending frame.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt==CLK_DIV-1).
- Scan: on tick, idx advances by 1 and wraps NUM_DIGITS-1 -> 0. wrap = tick && idx==NUM_DIGITS-1. frame_done is a registered pulse asserted in the cycle after wrap.
- Handshake: load_ready = !pending_full. Accept when load_valid && load_ready; pending <= load bus; pending_full <= 1. load_valid with load_ready=0 is ignored; the source must hold the data.
- Frame commit: on wrap with pending_full=1, active <= pending and pending_full <= 0. load_ready rises in the following cycle. An accept in the same cycle as wrap (pending empty) commits at the next wrap, not the current one.
- Leading-zero suppression (lz_en=1): digit i > 0 is suppressed when the active digits i..NUM_DIGITS-1 are all 0 and none of them has dp set. Digit 0 is never suppressed. lz_en is sampled live.
- Digit i is dark when blank[i] is set or it is suppressed. A dark digit drives all segments and dp inactive, and its anode stays inactive.
- Brightness: the anode for idx is active only while cnt < duty. duty is sampled live each cycle.
- Output stage: seg, dp and an are registered; they reflect the idx and cnt of the previous cycle (latency 1). Polarity inversion is applied at the register input.
- Decode: standard hex. 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001 (active-high form).

Decomposition:
- Shared package seg7_pkg: the 16-entry hex segment constants, the SEG_OFF constant, and a helper function for the polarity apply.
- One sub-module, seg7_hex_decode: combinational 4-bit code -> 7-bit active-high pattern.
- The top level holds the prescaler, scan index, pending and active buffers, leading-zero logic and output registers.

Test Plan:
- Reset: NUM_DIGITS=4, CLK_DIV=4, active-low polarity. Hold rst_n=0 for 3 cycles, then release -> an=4'b1111, seg=7'h7F, dp=1, load_ready=1, frame_done=0.
- Scan order: load 16'h1234 with dp=0, blank=0, duty=4 -> after commit, an steps 1110, 1101, 1011, 0111, each held 4 cycles. seg shows ~pattern for 4, 3, 2, 1. frame_done pulses every 16 cycles.
- Tear-free commit: mid-frame load 16'hABCD -> load_ready drops the next cycle. Old digits finish the current frame. New digits appear from digit 0 of the next frame, and load_ready returns 1 after the wrap.
- Back-pressure: second load_valid while pending_full=1 -> not accepted. Once committed, the frame holds the first load's data only.
- Leading zeros: digits 16'h0050, lz_en=1 -> digits 3 and 2 dark (an bit stays 1), digits 1 and 0 show 5 and 0. Set dp[3]=1 -> digit 3 shows 0 with dp lit.
- Brightness: duty=1 -> each anode is active for exactly 1 of 4 cycles per slot. duty=0 -> an stays all inactive. duty=7 (>=CLK_DIV) -> full on.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7 scan multiplexer.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Entry n is the active-high pattern for hex code n.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
      7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
      7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
      7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
   };

   function automatic logic [6:0] seg_pol(
      input logic [6:0] v,
      input logic       act_low
   );
      return act_low ? ~v : v;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex code to active-high 7-segment pattern.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_HEX[code_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with tear-free frame loading,
// PWM brightness, leading-zero suppression and selectable polarity.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int CLK_DIV     = 100,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit DIG_ACT_LOW = 1'b1,
   parameter int DUTY_W      = $clog2(CLK_DIV + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_digits,
   input  logic [NUM_DIGITS-1:0]   load_dp,
   input  logic [NUM_DIGITS-1:0]   load_blank,
   input  logic                    lz_en,
   input  logic [DUTY_W-1:0]       duty,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int N  = NUM_DIGITS;
   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [N-1:0]  AN_ONE   = {{(N-1){1'b0}}, 1'b1};
   localparam logic [6:0]    SEG_IDLE = seg_pol(SEG_OFF, SEG_ACT_LOW);
   localparam logic [N-1:0]  AN_IDLE  = {N{DIG_ACT_LOW}};

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [4*N-1:0] pend_dig_q, act_dig_q;
   logic [N-1:0]   pend_dp_q, act_dp_q;
   logic [N-1:0]   pend_blank_q, act_blank_q;
   logic           pend_full_q;
   logic           frame_done_q;
   logic [6:0]     seg_q, seg_d;
   logic           dp_q, dp_d;
   logic [N-1:0]   an_q, an_d;

   logic           tick, wrap, accept;
   logic [N-1:0]   dark;
   logic [3:0]     cur_code;
   logic [6:0]     cur_seg;
   logic           cur_dark, lit;

   assign tick   = (cnt_q == CNT_LAST);
   assign wrap   = tick && (idx_q == IDX_LAST);
   assign accept = load_valid && !pend_full_q;

   assign cnt_d = tick ? '0 : cnt_q + 1'b1;
   assign idx_d = !tick ? idx_q : (wrap ? '0 : idx_q + 1'b1);

   // A digit is suppressed when it and every digit above it are zero
   // with no dp lit; shifting leaves only that upper run to test.
   always_comb begin
      dark = act_blank_q;
      for (int i = 1; i < N; i++) begin
         dark[i] = act_blank_q[i] |
                   (lz_en &&
                    ((act_dig_q >> (4 * i)) == '0) &&
                    ((act_dp_q >> i) == '0));
      end
   end

   assign cur_code = act_dig_q[{idx_q, 2'b00} +: 4];
   assign cur_dark = dark[idx_q];
   assign lit      = !cur_dark && (DUTY_W'(cnt_q) < duty);

   seg7_hex_decode u_dec (
      .code_i (cur_code),
      .seg_o  (cur_seg)
   );

   always_comb begin
      seg_d = seg_pol(cur_dark ? SEG_OFF : cur_seg, SEG_ACT_LOW);
      dp_d  = (!cur_dark && act_dp_q[idx_q]) ^ SEG_ACT_LOW;
      an_d  = (lit ? (AN_ONE << idx_q) : '0) ^ AN_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '1;
         pend_full_q  <= 1'b0;
         act_dig_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '1;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_IDLE;
         dp_q         <= SEG_ACT_LOW;
         an_q         <= AN_IDLE;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_done_q <= wrap;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         if (accept) begin
            pend_dig_q   <= load_digits;
            pend_dp_q    <= load_dp;
            pend_blank_q <= load_blank;
            pend_full_q  <= 1'b1;
         end else if (wrap && pend_full_q) begin
            act_dig_q   <= pend_dig_q;
            act_dp_q    <= pend_dp_q;
            act_blank_q <= pend_blank_q;
            pend_full_q <= 1'b0;
         end
      end
   end

   assign load_ready = !pend_full_q;
   assign frame_done = frame_done_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;

endmodule
